// File: rtl/regfile_sb_if.sv
// Register-file / scoreboard bus: writeback port, two read ports and the issue-side hazard check.
interface regfile_sb_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
  logic            RegWrite;
  logic [AW-1:0]   RD;
  logic [XLEN-1:0] WriteData;
  logic [AW-1:0]   RS1;
  logic [AW-1:0]   RS2;
  logic [XLEN-1:0] ReadData1;
  logic [XLEN-1:0] ReadData2;
  logic            IssueValid;
  logic [AW-1:0]   IssueRD;
  logic            Busy1;
  logic            Busy2;
  logic            Stall;

  modport master (
    output RegWrite, RD, WriteData, RS1, RS2, IssueValid, IssueRD,
    input  ReadData1, ReadData2, Busy1, Busy2, Stall
  );

  modport slave (
    input  RegWrite, RD, WriteData, RS1, RS2, IssueValid, IssueRD,
    output ReadData1, ReadData2, Busy1, Busy2, Stall
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard; r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/pending-clear to the read side.
module regfile_sb #(
    parameter int              XLEN     = 64,
    parameter int              NREG     = 32,
    parameter int              INIT_IDX = 21,
    parameter logic [XLEN-1:0] INIT_VAL = XLEN'(1)
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_reg [NREG];
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic [NREG-1:0] pend_view;
  logic            wr_en;
  logic            issue_en;
  logic            fwd1;
  logic            fwd2;
  logic            busy1;
  logic            busy2;
  logic            waw;
  logic            stall;

  assign wr_en = bus.RegWrite && !reset && (bus.RD != '0);

`ifdef REGFILE_BYPASS_EN
  // A writeback landing this cycle already resolves the hazard it would report.
  assign fwd1      = wr_en && (bus.RD == bus.RS1);
  assign fwd2      = wr_en && (bus.RD == bus.RS2);
  assign pend_view = pending_reg & ~(wr_en ? (NREG'(1) << bus.RD) : '0);
`else
  assign fwd1      = 1'b0;
  assign fwd2      = 1'b0;
  assign pend_view = pending_reg;
`endif

  always_comb begin
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    if (!reset && bus.RS1 != '0)
      bus.ReadData1 = fwd1 ? bus.WriteData : regs_reg[bus.RS1];
    if (!reset && bus.RS2 != '0)
      bus.ReadData2 = fwd2 ? bus.WriteData : regs_reg[bus.RS2];
  end

  assign busy1     = !reset && pend_view[bus.RS1];
  assign busy2     = !reset && pend_view[bus.RS2];
  assign waw       = !reset && pend_view[bus.IssueRD];
  assign stall     = !reset && bus.IssueValid && (busy1 || busy2 || waw);
  assign bus.Busy1 = busy1;
  assign bus.Busy2 = busy2;
  assign bus.Stall = stall;

  assign issue_en = bus.IssueValid && !stall && !reset && (bus.IssueRD != '0);

  // Set beats clear when issue and writeback hit the same register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pending_next[gi] = 1'b0;
      end else begin : g_bit
        assign pending_next[gi] = (issue_en && bus.IssueRD == AW'(gi)) ? 1'b1 :
                                  (wr_en && bus.RD == AW'(gi))       ? 1'b0 :
                                  pending_reg[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      pending_reg <= '0;
    else
      pending_reg <= pending_next;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (reset)
        regs_reg[i] <= (i == INIT_IDX && INIT_IDX != 0) ? INIT_VAL : '0;
      else if (wr_en && bus.RD == AW'(i))
        regs_reg[i] <= bus.WriteData;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard-driven bench for regfile_sb: expectations queued at drive time, compared at sample time.
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .INIT_IDX(21), .INIT_VAL(64'd1)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef enum int {S_RD1, S_RD2, S_BUSY1, S_BUSY2, S_STALL} sel_t;
  typedef struct {
    string       tag;
    sel_t        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_txn    = 0;
  logic [63:0] mdl_regs [NREG];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input sel_t sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Let combinational outputs settle, then retire every queued expectation.
  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    int          n;
    #1;
    n = sb_q.size();
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      case (e.sel)
        S_RD1:   obs = bus.ReadData1;
        S_RD2:   obs = bus.ReadData2;
        S_BUSY1: obs = 64'(bus.Busy1);
        S_BUSY2: obs = 64'(bus.Busy2);
        default: obs = 64'(bus.Stall);
      endcase
      check_val(e.tag, obs, e.exp);
    end
    n_txn++;
    $display("txn %0d: %0d checks, t=%0t", n_txn, n, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.RegWrite = 1'b0; bus.RD = '0; bus.WriteData = '0;
    bus.RS1 = '0; bus.RS2 = '0; bus.IssueValid = 1'b0; bus.IssueRD = '0;
  endtask

  task automatic hazards(input string tag, input logic b1, input logic b2, input logic st);
    push_exp({tag, "_busy1"}, S_BUSY1, 64'(b1));
    push_exp({tag, "_busy2"}, S_BUSY2, 64'(b2));
    push_exp({tag, "_stall"}, S_STALL, 64'(st));
  endtask

  initial begin
    logic bp;
    int   rd, ra, rb;
    logic [63:0] wd;
`ifdef REGFILE_BYPASS_EN
    bp = 1'b1;
`else
    bp = 1'b0;
`endif
    idle();
    reset = 1'b1;
    cyc(); cyc();

    // Outputs held quiet during reset even with live requests.
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd5; bus.RS1 = 5'd21; bus.RS2 = 5'd5;
    push_exp("rst_rd1", S_RD1, 64'd0);
    hazards("rst", 1'b0, 1'b0, 1'b0);
    drain();
    idle();
    cyc();
    reset = 1'b0;

    for (int i = 0; i < NREG; i++) begin
      bus.RS1 = AW'(i); bus.RS2 = AW'(NREG - 1 - i);
      push_exp($sformatf("init_rd1_%0d", i), S_RD1, (i == 21) ? 64'd1 : 64'd0);
      push_exp($sformatf("init_rd2_%0d", NREG - 1 - i), S_RD2, (NREG - 1 - i == 21) ? 64'd1 : 64'd0);
      hazards("init", 1'b0, 1'b0, 1'b0);
      drain();
    end

    // r0 ignores writes.
    idle();
    bus.RegWrite = 1'b1; bus.RD = '0; bus.WriteData = 64'hDEAD;
    push_exp("r0_wr_rd1", S_RD1, 64'd0);
    drain();
    cyc();
    idle();
    push_exp("r0_rd1", S_RD1, 64'd0);
    drain();

    // RAW hazard on r5, resolved by writeback.
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd5;
    hazards("iss5", 1'b0, 1'b0, 1'b0);
    drain();
    cyc();
    idle();
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd6; bus.RS1 = 5'd5;
    hazards("raw5", 1'b1, 1'b0, 1'b1);
    drain();
    cyc();
    idle();
    bus.RegWrite = 1'b1; bus.RD = 5'd5; bus.WriteData = 64'h1234; bus.RS1 = 5'd5; bus.RS2 = 5'd6;
    push_exp("wb5_rd1", S_RD1, bp ? 64'h1234 : 64'd0);
    hazards("wb5", bp ? 1'b0 : 1'b1, 1'b0, 1'b0);
    drain();
    cyc();
    idle();
    bus.RS1 = 5'd5;
    push_exp("after5_rd1", S_RD1, 64'h1234);
    hazards("after5", 1'b0, 1'b0, 1'b0);
    drain();

    // Same-cycle set and clear on r7: set wins.
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd7; bus.RegWrite = 1'b1; bus.RD = 5'd7; bus.WriteData = 64'h77;
    hazards("sc7", 1'b0, 1'b0, 1'b0);
    drain();
    cyc();
    idle();
    bus.RS1 = 5'd7; bus.IssueValid = 1'b1; bus.IssueRD = 5'd7;
    push_exp("sc7_rd1", S_RD1, 64'h77);
    hazards("sc7_after", 1'b1, 1'b0, 1'b1);
    drain();
    idle();
    bus.RegWrite = 1'b1; bus.RD = 5'd7; bus.WriteData = 64'h70;
    cyc();
    idle();
    bus.RS2 = 5'd7; bus.IssueValid = 1'b1; bus.IssueRD = 5'd7;
    push_exp("clr7_rd2", S_RD2, 64'h70);
    hazards("clr7", 1'b0, 1'b0, 1'b0);
    drain();
    cyc();
    idle();
    bus.RegWrite = 1'b1; bus.RD = 5'd7; bus.WriteData = 64'h71;
    cyc();
    idle();

    // Forwarding check on r9.
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd9;
    cyc();
    idle();
    bus.RegWrite = 1'b1; bus.RD = 5'd9; bus.WriteData = 64'hABCD; bus.RS2 = 5'd9;
    push_exp("fwd9_rd2", S_RD2, bp ? 64'hABCD : 64'd0);
    hazards("fwd9", 1'b0, bp ? 1'b0 : 1'b1, 1'b0);
    drain();
    cyc();
    idle();
    bus.RS2 = 5'd9;
    push_exp("after9_rd2", S_RD2, 64'hABCD);
    hazards("after9", 1'b0, 1'b0, 1'b0);
    drain();

    // WAW on r10 while its writeback lands.
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd10;
    cyc();
    idle();
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd10; bus.RegWrite = 1'b1; bus.RD = 5'd10; bus.WriteData = 64'h5;
    hazards("waw10", 1'b0, 1'b0, bp ? 1'b0 : 1'b1);
    drain();
    cyc();
    idle();
    bus.RS1 = 5'd10;
    hazards("after10", bp ? 1'b1 : 1'b0, 1'b0, 1'b0);
    drain();
    bus.RegWrite = 1'b1; bus.RD = 5'd10; bus.WriteData = 64'h6;
    cyc();
    idle();

    // Reset mid-operation discards the pending write and the writeback.
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd3;
    cyc();
    idle();
    reset = 1'b1;
    bus.RegWrite = 1'b1; bus.RD = 5'd3; bus.WriteData = 64'hFFFF; bus.RS1 = 5'd3;
    bus.IssueValid = 1'b1; bus.IssueRD = 5'd4;
    push_exp("rst3_rd1", S_RD1, 64'd0);
    hazards("rst3", 1'b0, 1'b0, 1'b0);
    drain();
    cyc();
    reset = 1'b0;
    idle();
    bus.RS1 = 5'd3; bus.RS2 = 5'd4;
    push_exp("post3_rd1", S_RD1, 64'd0);
    hazards("post3", 1'b0, 1'b0, 1'b0);
    drain();
    bus.RS1 = 5'd5; bus.RS2 = 5'd21;
    push_exp("post_rd5", S_RD1, 64'd0);
    push_exp("post_rd21", S_RD2, 64'd1);
    drain();

    // Random write/read-back against a reference array.
    for (int i = 0; i < NREG; i++) mdl_regs[i] = (i == 21) ? 64'd1 : 64'd0;
    for (int k = 0; k < 24; k++) begin
      rd = $urandom_range(0, NREG - 1);
      ra = $urandom_range(0, NREG - 1);
      rb = $urandom_range(0, NREG - 1);
      wd = {$urandom, $urandom};
      idle();
      bus.RegWrite = 1'b1; bus.RD = AW'(rd); bus.WriteData = wd;
      bus.RS1 = AW'(ra); bus.RS2 = AW'(rb);
      push_exp($sformatf("rnd_rd1_%0d", ra), S_RD1,
               (ra == 0) ? 64'd0 : (bp && ra == rd) ? wd : mdl_regs[ra]);
      push_exp($sformatf("rnd_rd2_%0d", rb), S_RD2,
               (rb == 0) ? 64'd0 : (bp && rb == rd) ? wd : mdl_regs[rb]);
      drain();
      cyc();
      if (rd != 0) mdl_regs[rd] = wd;
    end
    idle();
    for (int i = 0; i < NREG; i++) begin
      bus.RS1 = AW'(i);
      push_exp($sformatf("final_rd1_%0d", i), S_RD1, mdl_regs[i]);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 64, register data width.
REQ-002 SHALL have parameter NREG, default 32, number of registers (power of two, >=2); AW = log2(NREG).
REQ-003 SHALL have parameter INIT_IDX, default 21, index loaded with INIT_VAL at reset.
REQ-004 SHALL have parameter INIT_VAL, default 1, reset value of register INIT_IDX.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have reset  in  1  synchronous active-high reset.
REQ-007 SHALL have RegWrite  in  1  writeback enable.
REQ-008 SHALL have RD  in  AW  writeback register index.
REQ-009 SHALL have WriteData  in  XLEN  writeback data.
REQ-010 SHALL have RS1, RS2  in  AW each  read indices.
REQ-011 SHALL have ReadData1, ReadData2  out  XLEN each  read data.
REQ-012 SHALL have IssueValid  in  1  instruction issuing a future write to IssueRD.
REQ-013 SHALL have IssueRD  in  AW  destination of issuing instruction.
REQ-014 SHALL have Busy1, Busy2  out  1 each  pending-write flag of RS1/RS2.
REQ-015 SHALL have Stall  out  1  issue blocked by hazard.

Function
REQ-016 Reads SHALL be combinational; ReadDataN = 0 when RSN = 0 or reset = 1, else register[RSN].
REQ-017 A write SHALL occur on a rising clk edge when RegWrite = 1, reset = 0, and RD != 0; register 0 SHALL never change.
REQ-018 Scoreboard SHALL hold one pending bit per register; bit 0 SHALL be constant 0.
REQ-019 Busy1/Busy2 SHALL equal pending[RS1]/pending[RS2], subject to REQ-030.
REQ-020 Stall SHALL be 1 when IssueValid = 1 and any of Busy1, Busy2, or the IssueRD WAW check (pending[IssueRD], subject to REQ-030) is 1; otherwise Stall = 0.
REQ-021 pending[IssueRD] SHALL set on a rising edge when IssueValid = 1, Stall = 0, and IssueRD != 0.
REQ-022 pending[RD] SHALL clear on a rising edge when RegWrite = 1 and RD != 0.
REQ-023 When set and clear target the same index in one cycle, set SHALL win.
REQ-024 Writeback to a non-pending register SHALL still update data and leave pending at 0.
REQ-025 There SHALL be no latency beyond one edge: data and pending updates are visible to reads in the cycle after the edge.

Reset
REQ-026 At a rising edge with reset = 1, all registers SHALL become 0 except register INIT_IDX = INIT_VAL (ignored if INIT_IDX = 0).
REQ-027 Reset SHALL clear all pending bits, with Busy1 = Busy2 = Stall = 0 while reset = 1.
REQ-028 RegWrite and IssueValid SHALL be ignored in any reset cycle, and in-flight pending writes SHALL be discarded (reset mid-operation).

Configuration
REQ-029 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined, when RegWrite = 1 and RD = RSN != 0, ReadDataN SHALL = WriteData, and the pending bit of RSN or IssueRD SHALL read as 0 for Busy and Stall in that cycle.
REQ-031 Without REGFILE_BYPASS_EN, reads SHALL return stored contents only, and Busy/Stall SHALL use raw pending bits.

Verification
REQ-032 Reset, then read all indices -> register 21 reads 1, all others read 0; Busy1 = Busy2 = Stall = 0.
REQ-033 Write 0xDEAD to RD = 0, then read RS1 = 0 -> ReadData1 = 0.
REQ-034 Issue IssueRD = 5, then next cycle IssueValid with RS1 = 5 -> Busy1 = 1, Stall = 1; writeback RD = 5 with 0x1234 -> next cycle Busy1 = 0 and ReadData1 = 0x1234.
REQ-035 Same-cycle issue IssueRD = 7 and writeback RD = 7 -> pending[7] = 1 afterwards.
REQ-036 With REGFILE_BYPASS_EN, pending[9] set, writeback RD = 9 with 0xABCD and RS2 = 9 in same cycle -> ReadData2 = 0xABCD, Busy2 = 0; without the macro -> old value, Busy2 = 1.
REQ-037 Set pending[3], assert reset together with RegWrite to RD = 3 -> register 3 = 0, pending[3] = 0.
